// File: rtl/vga_timing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_timing_pkg                                                       |
// | 800x600 VGA timing constants and line-fetch FSM state type.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package vga_timing_pkg;

  // Horizontal: sync, back porch, active, front porch (1056 clocks/line)
  localparam int HTA = 128;
  localparam int HTB = 88;
  localparam int HTC = 800;
  localparam int HTD = 40;
  // Vertical: sync, back porch, active, front porch (628 lines/frame)
  localparam int VTA = 4;
  localparam int VTB = 23;
  localparam int VTC = 600;
  localparam int VTD = 1;

  localparam int HSTART  = HTA + HTB;
  localparam int VSTART  = VTA + VTB;
  localparam int HACTIVE = HTC;
  localparam int VACTIVE = VTC;
  localparam int PIX_W   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_line_fetch_ctrl_if                                               |
// | Burst request / read-data bus between line fetcher and mem arbiter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vga_line_fetch_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int PIX_W  = 24
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              rd_valid;
  logic [PIX_W-1:0]  rd_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/vga_line_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_line_fetch_ctrl                                                  |
// | Prefetches the next visible line into a ping-pong line buffer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vga_line_fetch_ctrl #(
  parameter int WIDTH   = 10,
  parameter int HSTART  = vga_timing_pkg::HSTART,
  parameter int VSTART  = vga_timing_pkg::VSTART,
  parameter int HACTIVE = vga_timing_pkg::HACTIVE,
  parameter int VACTIVE = vga_timing_pkg::VACTIVE,
  parameter int BURST   = 32,
  parameter int ADDR_W  = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH+1:0]            line_cnt,
  input  logic [WIDTH+1:0]            ver_cnt,
  input  logic                        en,
  input  logic [ADDR_W-1:0]           fb_base,
  input  logic                        err_clr,
  vga_line_fetch_ctrl_if.master       mem,
  output logic                        lb_wr_en,
  output logic [WIDTH:0]              lb_wr_addr,
  output logic [vga_timing_pkg::PIX_W-1:0] lb_wr_data,
  output logic [WIDTH:0]              lb_rd_addr,
  output logic                        de,
  output logic                        busy,
  output logic                        underrun,
  output logic                        err_underrun
);
  import vga_timing_pkg::*;

  localparam int CW     = WIDTH + 2;
  localparam int NBURST = HACTIVE / BURST;
  localparam int BC_W   = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int WC_W   = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [CW-1:0]     c_hstart     = CW'(HSTART);
  localparam logic [CW-1:0]     c_hend       = CW'(HSTART + HACTIVE - 1);
  localparam logic [CW-1:0]     c_vstart     = CW'(VSTART);
  localparam logic [CW-1:0]     c_vend       = CW'(VSTART + VACTIVE - 1);
  localparam logic [CW-1:0]     c_trig_lo    = CW'(VSTART - 1);
  localparam logic [CW-1:0]     c_trig_hi    = CW'(VSTART + VACTIVE - 2);
  localparam logic [ADDR_W-1:0] c_hactive_a  = ADDR_W'(HACTIVE);
  localparam logic [ADDR_W-1:0] c_burst_a    = ADDR_W'(BURST);
  localparam logic [BC_W-1:0]   c_last_burst = BC_W'(NBURST - 1);
  localparam logic [WC_W-1:0]   c_last_word  = WC_W'(BURST - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              first_q, first_d;
  logic              req_valid_q, req_valid_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic              bank_q, bank_d;
  logic              lb_wr_en_q, lb_wr_en_d;
  logic [WIDTH:0]    lb_wr_addr_q, lb_wr_addr_d;
  logic [PIX_W-1:0]  lb_wr_data_q, lb_wr_data_d;
  logic              busy_q, busy_d;
  logic              underrun_q, underrun_d;
  logic              err_q, err_d;

  logic             w_frame_start;
  logic             w_trigger;
  logic [WIDTH-1:0] w_rx;

  assign w_frame_start = (line_cnt == '0) && (ver_cnt == '0);
  assign w_trigger     = (line_cnt == '0) && (ver_cnt >= c_trig_lo) &&
                         (ver_cnt <= c_trig_hi) && en;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    line_addr_d  = line_addr_q;
    req_addr_d   = req_addr_q;
    first_d      = first_q;
    req_valid_d  = req_valid_q;
    burst_cnt_d  = burst_cnt_q;
    word_cnt_d   = word_cnt_q;
    x_d          = x_q;
    bank_d       = bank_q;
    lb_wr_en_d   = 1'b0;
    lb_wr_addr_d = lb_wr_addr_q;
    lb_wr_data_d = lb_wr_data_q;
    busy_d       = busy_q;
    underrun_d   = 1'b0;

    if (w_frame_start) begin
      base_d  = fb_base;
      first_d = 1'b1;
    end

    unique case (state_q)
      REQ: begin
        if (mem.req_ready) begin
          req_valid_d = 1'b0;
          state_d     = DATA;
        end
      end
      DATA: begin
        if (mem.rd_valid) begin
          lb_wr_en_d   = 1'b1;
          lb_wr_data_d = mem.rd_data;
          lb_wr_addr_d = {bank_q, x_q};
          x_d          = x_q + 1'b1;
          word_cnt_d   = word_cnt_q + 1'b1;
          if (word_cnt_q == c_last_word) begin
            word_cnt_d = '0;
            if (burst_cnt_q == c_last_burst) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              burst_cnt_d = burst_cnt_q + 1'b1;
              req_addr_d  = req_addr_q + c_burst_a;
              req_valid_d = 1'b1;
              state_d     = REQ;
            end
          end
        end
      end
      default: state_d = state_q;
    endcase

    // A trigger always advances line_addr, even when the line is skipped
    if (w_trigger) begin
      line_addr_d = first_q ? base_q : (line_addr_q + c_hactive_a);
      first_d     = 1'b0;
      if (busy_q) begin
        underrun_d = 1'b1;
      end else begin
        state_d     = REQ;
        req_valid_d = 1'b1;
        req_addr_d  = line_addr_d;
        burst_cnt_d = '0;
        word_cnt_d  = '0;
        x_d         = '0;
        bank_d      = ver_cnt[0] ^ c_trig_lo[0];
        busy_d      = 1'b1;
      end
    end

    err_d = underrun_d | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      line_addr_q  <= '0;
      req_addr_q   <= '0;
      first_q      <= 1'b1;
      req_valid_q  <= 1'b0;
      burst_cnt_q  <= '0;
      word_cnt_q   <= '0;
      x_q          <= '0;
      bank_q       <= 1'b0;
      lb_wr_en_q   <= 1'b0;
      lb_wr_addr_q <= '0;
      lb_wr_data_q <= '0;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      line_addr_q  <= line_addr_d;
      req_addr_q   <= req_addr_d;
      first_q      <= first_d;
      req_valid_q  <= req_valid_d;
      burst_cnt_q  <= burst_cnt_d;
      word_cnt_q   <= word_cnt_d;
      x_q          <= x_d;
      bank_q       <= bank_d;
      lb_wr_en_q   <= lb_wr_en_d;
      lb_wr_addr_q <= lb_wr_addr_d;
      lb_wr_data_q <= lb_wr_data_d;
      busy_q       <= busy_d;
      underrun_q   <= underrun_d;
      err_q        <= err_d;
    end
  end

  assign mem.req_valid = req_valid_q;
  assign mem.req_addr  = req_addr_q;
  assign lb_wr_en      = lb_wr_en_q;
  assign lb_wr_addr    = lb_wr_addr_q;
  assign lb_wr_data    = lb_wr_data_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;
  assign err_underrun  = err_q;

  // Display side reads the bank of the line being shown; low bits suffice mod 2^WIDTH
  assign de = (line_cnt >= c_hstart) && (line_cnt <= c_hend) &&
              (ver_cnt >= c_vstart) && (ver_cnt <= c_vend);
  assign w_rx       = line_cnt[WIDTH-1:0] - c_hstart[WIDTH-1:0];
  assign lb_rd_addr = de ? {ver_cnt[0] ^ c_vstart[0], w_rx} : '0;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_line_fetch_ctrl                                               |
// | Directed self-checking bench for the VGA line fetch controller.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vga_line_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] line_cnt, ver_cnt;
  logic        en, err_clr;
  logic [19:0] fb_base;
  logic        lb_wr_en, de, busy, underrun, err_underrun;
  logic [10:0] lb_wr_addr, lb_rd_addr;
  logic [23:0] lb_wr_data;

  int total = 0;
  int bad   = 0;

  vga_line_fetch_ctrl_if #(.ADDR_W(20), .PIX_W(24)) mif ();

  vga_line_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_cnt     (line_cnt),
    .ver_cnt      (ver_cnt),
    .en           (en),
    .fb_base      (fb_base),
    .err_clr      (err_clr),
    .mem          (mif),
    .lb_wr_en     (lb_wr_en),
    .lb_wr_addr   (lb_wr_addr),
    .lb_wr_data   (lb_wr_data),
    .lb_rd_addr   (lb_rd_addr),
    .de           (de),
    .busy         (busy),
    .underrun     (underrun),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int tag, input int x);
    return 24'(tag * 1024 + x) ^ 24'hA5A5A5;
  endfunction

  // Acts as arbiter + memory: 25 bursts, data one cycle after accept
  task automatic fetch_line(input logic [19:0] base, input logic bank, input int tag);
    int n;
    int x;
    for (int b = 0; b < 25; b++) begin
      n = 0;
      while (mif.req_valid !== 1'b1 && n < 64) begin
        tick();
        n++;
      end
      chk("req_valid", 32'(mif.req_valid), 32'd1);
      if (mif.req_valid !== 1'b1) return;
      chk("req_addr", 32'(mif.req_addr), 32'(base + 20'(b * 32)));
      chk("busy_fetch", 32'(busy), 32'd1);
      tick();
      chk("req_drop", 32'(mif.req_valid), 32'd0);
      for (int w = 0; w < 32; w++) begin
        x = b * 32 + w;
        mif.rd_valid = 1'b1;
        mif.rd_data  = pix(tag, x);
        tick();
        chk("lb_wr_en", 32'(lb_wr_en), 32'd1);
        chk("lb_wr_addr", 32'(lb_wr_addr), 32'({bank, 10'(x)}));
        chk("lb_wr_data", 32'(lb_wr_data), 32'(pix(tag, x)));
      end
      mif.rd_valid = 1'b0;
    end
    chk("busy_end", 32'(busy), 32'd0);
    tick();
    chk("lb_wr_en_idle", 32'(lb_wr_en), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    line_cnt      = 12'd1;
    ver_cnt       = 12'd1;
    en            = 1'b1;
    err_clr       = 1'b0;
    fb_base       = 20'h01000;
    mif.req_ready = 1'b1;
    mif.rd_valid  = 1'b0;
    mif.rd_data   = '0;
    #3;
    chk("rst_req_valid", 32'(mif.req_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lb_wr_en", 32'(lb_wr_en), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_err", 32'(err_underrun), 32'd0);
    chk("rst_de", 32'(de), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Frame start latches fb_base, then the first trigger at ver=26
    line_cnt = 12'd0; ver_cnt = 12'd0;
    tick();
    ver_cnt = 12'd26;
    tick();
    line_cnt = 12'd1;
    fetch_line(20'h01000, 1'b0, 26);

    line_cnt = 12'd0; ver_cnt = 12'd27;
    tick();
    line_cnt = 12'd1;
    fetch_line(20'h01320, 1'b1, 27);

    // Stall the arbiter: line 28 fetch stays in REQ
    mif.req_ready = 1'b0;
    line_cnt = 12'd0; ver_cnt = 12'd28;
    tick();
    line_cnt = 12'd1;
    chk("stall_req_valid", 32'(mif.req_valid), 32'd1);
    chk("stall_req_addr", 32'(mif.req_addr), 32'h01640);
    repeat (1100) tick();
    chk("stall_hold_valid", 32'(mif.req_valid), 32'd1);
    chk("stall_hold_addr", 32'(mif.req_addr), 32'h01640);
    chk("stall_no_underrun", 32'(underrun), 32'd0);
    chk("stall_no_err", 32'(err_underrun), 32'd0);

    // Every later trigger underruns but still advances the line address
    for (int v = 29; v <= 624; v++) begin
      line_cnt = 12'd0;
      ver_cnt  = 12'(v);
      err_clr  = (v == 30);
      if (v == 300) fb_base = 20'h40000;
      tick();
      chk("underrun_pulse", 32'(underrun), 32'd1);
      chk("err_set", 32'(err_underrun), 32'd1);
      line_cnt = 12'd1;
      err_clr  = 1'b0;
      tick();
      chk("underrun_one_cycle", 32'(underrun), 32'd0);
    end
    chk("stall_end_addr", 32'(mif.req_addr), 32'h01640);
    err_clr = 1'b1;
    tick();
    chk("err_clr", 32'(err_underrun), 32'd0);
    err_clr = 1'b0;

    mif.req_ready = 1'b1;
    fetch_line(20'h01640, 1'b0, 28);

    line_cnt = 12'd0; ver_cnt = 12'd625;
    tick();
    line_cnt = 12'd1;
    fetch_line(20'h01000 + 20'(599 * 800), 1'b1, 625);

    line_cnt = 12'd0; ver_cnt = 12'd626;
    tick();
    line_cnt = 12'd1;
    chk("no_trig_626_valid", 32'(mif.req_valid), 32'd0);
    chk("no_trig_626_busy", 32'(busy), 32'd0);
    chk("no_trig_626_underrun", 32'(underrun), 32'd0);

    // Next frame picks up the new base
    line_cnt = 12'd0; ver_cnt = 12'd0;
    tick();
    ver_cnt = 12'd26;
    tick();
    line_cnt = 12'd1;
    chk("new_frame_valid", 32'(mif.req_valid), 32'd1);
    chk("new_frame_addr", 32'(mif.req_addr), 32'h40000);

    // Async reset in the middle of a burst
    tick();
    mif.rd_valid = 1'b1;
    mif.rd_data  = 24'h123456;
    tick();
    tick();
    tick();
    chk("pre_rst_wr_en", 32'(lb_wr_en), 32'd1);
    chk("pre_rst_wr_addr", 32'(lb_wr_addr), 32'h002);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req_valid", 32'(mif.req_valid), 32'd0);
    chk("async_rst_wr_en", 32'(lb_wr_en), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_write", 32'(lb_wr_en), 32'd0);
    end
    mif.rd_valid = 1'b0;

    // No trigger accepted with en low
    en = 1'b0;
    line_cnt = 12'd0; ver_cnt = 12'd27;
    tick();
    line_cnt = 12'd1;
    chk("en_off_busy", 32'(busy), 32'd0);
    chk("en_off_req_valid", 32'(mif.req_valid), 32'd0);
    en = 1'b1;

    // Display-side mapping
    ver_cnt = 12'd27; line_cnt = 12'd215;
    #1;
    chk("de_before", 32'(de), 32'd0);
    line_cnt = 12'd216;
    #1;
    chk("de_first", 32'(de), 32'd1);
    chk("rd_addr_first", 32'(lb_rd_addr), 32'h000);
    line_cnt = 12'd1015;
    #1;
    chk("de_last", 32'(de), 32'd1);
    chk("rd_addr_last", 32'(lb_rd_addr), 32'h31F);
    line_cnt = 12'd1016;
    #1;
    chk("de_after", 32'(de), 32'd0);
    chk("rd_addr_after", 32'(lb_rd_addr), 32'h000);
    ver_cnt = 12'd28; line_cnt = 12'd216;
    #1;
    chk("rd_addr_bank1", 32'(lb_rd_addr), 32'h400);
    ver_cnt = 12'd627;
    #1;
    chk("de_below", 32'(de), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
